// File: rtl/i2f_vec_seq.sv
// i2f_vec_seq: walks a vector of 32-bit integers through one shared int-to-FP converter.
// Optional build macro I2F_SEQ_DYN_RM_EN: rm=111 resolves to frm when the operation starts.

module i2f_conv (
  input  logic [31:0] src,
  input  logic [2:0]  rounding_mode,
  input  logic        sp_dp,
  input  logic        is_unsigned,
  output logic [63:0] res,
  output logic        inexact
);
  logic        sign;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  msb;
  logic        lsb;
  logic        grd;
  logic        stk;
  logic        inc;
  logic [30:0] sp_body;
  logic        unused_norm_msb;

  always_comb begin
    sign = ~is_unsigned & src[31];
    mag  = sign ? (~src + 32'd1) : src;
    msb  = '0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) msb = 5'(i);
    norm = mag << (5'd31 - msb);
    lsb  = norm[8];
    grd  = norm[7];
    stk  = |norm[6:0];
    case (rounding_mode)
      3'b000:  inc = grd & (stk | lsb);
      3'b010:  inc = sign & (grd | stk);
      3'b011:  inc = ~sign & (grd | stk);
      3'b100:  inc = grd;
      default: inc = 1'b0;
    endcase
    // a mantissa carry ripples into the exponent field on its own
    sp_body = {8'(msb) + 8'd127, norm[30:8]} + 31'(inc);
    res     = '0;
    inexact = 1'b0;
    if (mag != 32'd0) begin
      if (sp_dp) begin
        res = {sign, 11'(msb) + 11'd1023, norm[30:0], 21'd0};
      end else begin
        res     = {32'd0, sign, sp_body};
        inexact = grd | stk;
      end
    end
  end

  assign unused_norm_msb = norm[31];
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one element read per cycle
// DRAIN | reads done, waiting for the last write to be presented
// FIN   | done pulse, then back to IDLE
module i2f_vec_seq #(
  parameter int VL_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [VL_W-1:0] vl,
  input  logic [2:0]      rm,
  input  logic [2:0]      frm,
  input  logic            sp_dp,
  input  logic            is_unsigned,
  input  logic            abort,
  output logic            src_re,
  output logic [VL_W-1:0] src_addr,
  input  logic [31:0]     src_rdata,
  output logic            dst_we,
  output logic [VL_W-1:0] dst_addr,
  output logic [63:0]     dst_wdata,
  output logic            busy,
  output logic            done,
  output logic            nx_flag
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state;
  logic [VL_W-1:0] vl_m1;
  logic [VL_W-1:0] rd_cnt;
  logic [VL_W-1:0] rd_idx;
  logic            rd_vld;
  logic            wr_nx;
  logic [2:0]      rm_q;
  logic            sp_q;
  logic            uns_q;
  logic [2:0]      rm_res;
  logic [63:0]     conv_res;
  logic            conv_nx;

`ifdef I2F_SEQ_DYN_RM_EN
  assign rm_res = (rm == 3'b111) ? frm : rm;
`else
  logic unused_frm;
  assign rm_res     = rm;
  assign unused_frm = ^frm;
`endif

  assign src_addr = rd_cnt;

  i2f_conv u_conv (
    .src           (src_rdata),
    .rounding_mode (rm_q),
    .sp_dp         (sp_q),
    .is_unsigned   (uns_q),
    .res           (conv_res),
    .inexact       (conv_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vl_m1     <= '0;
      rd_cnt    <= '0;
      rd_idx    <= '0;
      rd_vld    <= 1'b0;
      wr_nx     <= 1'b0;
      rm_q      <= '0;
      sp_q      <= 1'b0;
      uns_q     <= 1'b0;
      src_re    <= 1'b0;
      dst_we    <= 1'b0;
      dst_addr  <= '0;
      dst_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nx_flag   <= 1'b0;
    end else begin
      rd_vld   <= src_re;
      rd_idx   <= rd_cnt;
      dst_we   <= rd_vld;
      dst_addr <= rd_idx;
      wr_nx    <= conv_nx;
      if (rd_vld) dst_wdata <= conv_res;
      nx_flag  <= nx_flag | (dst_we & wr_nx);
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            vl_m1   <= vl - 1'b1;
            rm_q    <= rm_res;
            sp_q    <= sp_dp;
            uns_q   <= is_unsigned;
            rd_cnt  <= '0;
            rd_vld  <= 1'b0;
            dst_we  <= 1'b0;
            nx_flag <= 1'b0;
            busy    <= 1'b1;
            if (vl != '0) begin
              state  <= RUN;
              src_re <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          // compare against vl-1 so a full-range vl never wraps rd_cnt
          if (rd_cnt == vl_m1) begin
            src_re <= 1'b0;
            state  <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (dst_we && dst_addr == vl_m1) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (abort && state != IDLE) begin
        state  <= IDLE;
        src_re <= 1'b0;
        rd_vld <= 1'b0;
        dst_we <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2f_vec_seq.sv
// Directed bench for i2f_vec_seq: cycle-accurate checks of reads, writes, busy/done and NX.
module tb_i2f_vec_seq;
  localparam int VL_W = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start = 1'b0;
  logic [VL_W-1:0] vl = '0;
  logic [2:0]      rm = '0;
  logic [2:0]      frm = '0;
  logic            sp_dp = 1'b0;
  logic            is_unsigned = 1'b0;
  logic            abort = 1'b0;
  logic            src_re;
  logic [VL_W-1:0] src_addr;
  logic [31:0]     src_rdata = '0;
  logic            dst_we;
  logic [VL_W-1:0] dst_addr;
  logic [63:0]     dst_wdata;
  logic            busy;
  logic            done;
  logic            nx_flag;

  logic [31:0]     mem  [64];
  logic [63:0]     expw [64];
  int              nvec = 0;
  int              nmis = 0;
  logic            pend_vld = 1'b0;
  logic [VL_W-1:0] pend_addr = '0;

  always #5 clk = ~clk;

  i2f_vec_seq #(.VL_W(VL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vl          (vl),
    .rm          (rm),
    .frm         (frm),
    .sp_dp       (sp_dp),
    .is_unsigned (is_unsigned),
    .abort       (abort),
    .src_re      (src_re),
    .src_addr    (src_addr),
    .src_rdata   (src_rdata),
    .dst_we      (dst_we),
    .dst_addr    (dst_addr),
    .dst_wdata   (dst_wdata),
    .busy        (busy),
    .done        (done),
    .nx_flag     (nx_flag)
  );

  // read port: data for a request seen in cycle c is held across the edge that ends cycle c+1
  always @(negedge clk) begin
    src_rdata = pend_vld ? mem[pend_addr] : 32'd0;
    pend_vld  = src_re;
    pend_addr = src_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] s, input logic [63:0] e);
    mem[i]  = s;
    expw[i] = e;
  endtask

  // Call at a negedge. Checks every cycle from 1 to the end; exp_nx < 0 skips the NX check.
  task automatic run_op(input int n_el, input logic [2:0] rm_i, input logic sp_i,
                        input logic uns_i, input int abort_at, input int tail, input int exp_nx);
    int   done_cyc;
    int   last;
    logic live;
    logic rd_on;
    logic wr_on;
    done_cyc    = (n_el == 0) ? 1 : n_el + 3;
    last        = (abort_at != 0) ? abort_at + 1 : done_cyc + tail;
    vl          = VL_W'(n_el);
    rm          = rm_i;
    sp_dp       = sp_i;
    is_unsigned = uns_i;
    start       = 1'b1;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (n == 1) begin
        vl          = ~vl;
        rm          = ~rm;
        sp_dp       = ~sp_dp;
        is_unsigned = ~is_unsigned;
      end
      start = (n == 2) && (n_el >= 2);
      live  = (abort_at == 0) || (n <= abort_at);
      rd_on = live && n <= n_el;
      wr_on = live && n >= 3 && n <= n_el + 2;
      chk($sformatf("busy@%0d", n), 64'(busy), 64'(live && n <= done_cyc));
      chk($sformatf("done@%0d", n), 64'(done), 64'(live && n == done_cyc));
      chk($sformatf("src_re@%0d", n), 64'(src_re), 64'(rd_on));
      chk($sformatf("dst_we@%0d", n), 64'(dst_we), 64'(wr_on));
      if (rd_on) chk($sformatf("src_addr@%0d", n), 64'(src_addr), 64'(n - 1));
      if (wr_on) begin
        chk($sformatf("dst_addr@%0d", n), 64'(dst_addr), 64'(n - 3));
        chk($sformatf("dst_wdata@%0d", n), dst_wdata, expw[n - 3]);
      end
      abort = (n == abort_at);
    end
    abort = 1'b0;
    start = 1'b0;
    if (exp_nx >= 0) chk("nx_flag", 64'(nx_flag), 64'(exp_nx));
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_src_re", 64'(src_re), 64'd0);
    chk("rst_src_addr", 64'(src_addr), 64'd0);
    chk("rst_dst_we", 64'(dst_we), 64'd0);
    chk("rst_dst_addr", 64'(dst_addr), 64'd0);
    chk("rst_dst_wdata", dst_wdata, 64'd0);
    chk("rst_nx", 64'(nx_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RNE single, signed; last element loses its low bit
    load(0, 32'h0000_0000, 64'h0);
    load(1, 32'h0000_0001, 64'h3F80_0000);
    load(2, 32'hFFFF_FFFF, 64'hBF80_0000);
    load(3, 32'h0100_0001, 64'h4B80_0000);
    run_op(4, 3'b000, 1'b0, 1'b0, 0, 1, 1);

    // back-to-back: double, unsigned, exact
    load(0, 32'hFFFF_FFFF, 64'h41EF_FFFF_FFE0_0000);
    load(1, 32'h0000_0002, 64'h4000_0000_0000_0000);
    run_op(2, 3'b000, 1'b1, 1'b1, 0, 2, 0);

    run_op(0, 3'b000, 1'b0, 1'b0, 0, 2, 0);

    // abort in cycle 4; element 2 is inexact but never written
    load(0, 32'd3, 64'h4040_0000);
    load(1, 32'd5, 64'h40A0_0000);
    load(2, 32'h0100_0001, 64'h4B80_0000);
    for (int i = 3; i < 8; i++) load(i, 32'd9, 64'h4110_0000);
    run_op(8, 3'b000, 1'b0, 1'b0, 4, 0, 0);

    // restarted in the cycle right after the abort; RMM
    load(0, 32'h0100_0001, 64'h4B80_0001);
    load(1, 32'h0100_0003, 64'h4B80_0002);
    load(2, 32'd7, 64'h40E0_0000);
    run_op(3, 3'b100, 1'b0, 1'b0, 0, 2, 1);

    // RUP
    load(0, 32'h0100_0001, 64'h4B80_0001);
    load(1, 32'hFEFF_FFFF, 64'hCB80_0000);
    run_op(2, 3'b011, 1'b0, 1'b0, 0, 2, 1);

    // RDN, including the most negative integer
    load(0, 32'h0100_0001, 64'h4B80_0000);
    load(1, 32'hFEFF_FFFF, 64'hCB80_0001);
    load(2, 32'h8000_0000, 64'hCF00_0000);
    run_op(3, 3'b010, 1'b0, 1'b0, 0, 2, 1);

    // rm=111: RZ by default, frm=RZ under the dynamic-mode build
    frm = 3'b001;
    load(0, 32'h0100_0001, 64'h4B80_0000);
    run_op(1, 3'b111, 1'b0, 1'b0, 0, 2, -1);

    // full-length vector, double precision, reference from the simulator's own real conversion
    for (int i = 0; i < 63; i++) begin
      int v;
      v = (i == 62) ? 32'h8000_0000 : i * 123457 - 3000000;
      load(i, 32'(v), $realtobits(real'(v)));
    end
    run_op(63, 3'b000, 1'b1, 1'b0, 0, 2, 0);

    // reset in the middle of RUN
    for (int i = 0; i < 8; i++) load(i, 32'h0100_0001, 64'h4B80_0000);
    vl = 6'd8; rm = 3'b000; sp_dp = 1'b0; is_unsigned = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dst_we", 64'(dst_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_src_re", 64'(src_re), 64'd0);
    chk("mid_rst_dst_we", 64'(dst_we), 64'd0);
    chk("mid_rst_wdata", dst_wdata, 64'd0);
    chk("mid_rst_nx", 64'(nx_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk($sformatf("post_rst_we@%0d", n), 64'(dst_we), 64'd0);
      chk($sformatf("post_rst_busy@%0d", n), 64'(busy), 64'd0);
    end

    // recovery after reset: unsigned single, with a rounding carry into the exponent
    load(0, 32'h8000_0000, 64'h4F00_0000);
    load(1, 32'hFFFF_FFFF, 64'h4F80_0000);
    run_op(2, 3'b000, 1'b0, 1'b1, 0, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
